// File: rtl/mem_access_unit.sv
// Two-channel RAM access sequencer: fetch/data arbitration, little-endian lane steering,
// load extension and alignment checking. Define MAU_TIMEOUT_EN to bound ACCESS wait states.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_into_mcu,
  input  logic              ram_ready,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [3:0]        byte_en,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0]        SZ_BYTE   = 2'b00;
  localparam logic [1:0]        SZ_HALF   = 2'b01;
  localparam logic [1:0]        SZ_WORD   = 2'b10;
  localparam logic [1:0]        SZ_RSVD   = 2'b11;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(3);

  state_t            state, state_nxt;
  logic              ch_data;
  logic              last_data;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              grant_any;
  logic              grant_data;
  logic              illegal;
  logic              timeout_hit;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] steer_load(input logic [1:0] size, input logic [1:0] lane,
                                             input logic sgn, input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return sgn ? 32'(b) : {24'd0, b};
      SZ_HALF: return sgn ? 32'(h) : {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Ties go to the channel that was not granted last; last_data resets to fetch.
  assign grant_any  = if_req | d_req;
  assign grant_data = d_req & (~if_req | ~last_data);
  assign illegal    = grant_data &
                      ((d_size == SZ_RSVD) |
                       ((d_size == SZ_HALF) & d_addr[0]) |
                       ((d_size == SZ_WORD) & (d_addr[1:0] != 2'b00)));

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ACCESS) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  localparam bit TIMEOUT_OK = (TIMEOUT >= 1);

  // Without the bound, ACCESS waits for ram_ready indefinitely.
  assign timeout_hit = 1'b0 & TIMEOUT_OK;
`endif

  always_comb begin
    state_nxt   = state;
    cs          = 1'b0;
    we          = 1'b0;
    oe          = 1'b0;
    byte_en     = '0;
    address     = '0;
    ram_data_in = '0;
    if_ready    = 1'b0;
    d_ready     = 1'b0;
    if_err      = 1'b0;
    d_err       = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_any) state_nxt = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        cs      = 1'b1;
        we      = we_q;
        oe      = ~we_q;
        address = addr_q & ~LANE_MASK;
        byte_en = lane_enables(size_q, addr_q[1:0]);
        if (we_q) ram_data_in = replicate_store(size_q, wdata_q);
        if (ram_ready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
        if_ready  = ~ch_data;
        d_ready   = ch_data;
        d_err     = ch_data & err_q;
`ifdef MAU_TIMEOUT_EN
        if_err    = ~ch_data & err_q;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and read-result registers; ram_ready beats an expiring counter on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_data   <= 1'b0;
      last_data <= 1'b0;
      err_q     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        ch_data   <= grant_data;
        last_data <= grant_data;
        err_q     <= illegal;
      end
      if (state == ACCESS) begin
        if (ram_ready) begin
          err_q <= 1'b0;
          if (!we_q) begin
            if (ch_data) d_rdata <= steer_load(size_q, addr_q[1:0], sgn_q, ram_data_into_mcu);
            else         if_rdata <= ram_data_into_mcu;
          end
        end else if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Request attributes latched at grant; only consumed while ACCESS is active.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_any) begin
      addr_q  <= grant_data ? d_addr : (if_addr & ~LANE_MASK);
      size_q  <= grant_data ? d_size : SZ_WORD;
      sgn_q   <= grant_data & d_signed;
      we_q    <= grant_data & d_we;
      wdata_q <= d_wdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized transactions against a
// transaction-level model, and hand sequences for arbitration, timeout and reset abort.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_into_mcu;
  logic        ram_ready;
  logic        cs;
  logic        we;
  logic        oe;
  logic [3:0]  byte_en;
  logic        busy;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .ram_data_in(ram_data_in), .ram_data_into_mcu(ram_data_into_mcu),
    .ram_ready(ram_ready), .cs(cs), .we(we), .oe(oe), .byte_en(byte_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rw;
    int          waits;
    bit          err;
    logic [3:0]  be;
    logic [31:0] wbus;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[14];

  // Observations from the most recent transaction
  int          lat, ncs;
  logic [3:0]  o_be;
  logic [31:0] o_ad, o_wb, o_rd;
  logic        o_wr, o_oe, o_er;
  bit          o_stable, o_one;
  logic [31:0] exp_if, exp_d;

  // Random-phase scratch
  bit          r_isd, r_wr, r_sg, e_err;
  int unsigned r_sz, r_a, r_wd, r_rw, r_wt;
  logic [11:0] pat_d, pat_i;
  int          nready;

  function automatic bit m_illegal(int unsigned sz, int unsigned a);
    return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic int unsigned m_be(bit isd, int unsigned sz, int unsigned a);
    if (!isd || sz == 2) return 15;
    if (sz == 1) return (a % 4 >= 2) ? 12 : 3;
    return 1 << (a % 4);
  endfunction

  function automatic int unsigned m_load(int unsigned sz, bit sg, int unsigned a, int unsigned w);
    int unsigned v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> ((a % 4 >= 2) ? 16 : 0)) % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic int unsigned m_wbus(int unsigned sz, int unsigned wd);
    if (sz == 0) return (wd % 256) * 32'h0101_0101;
    if (sz == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_signed = 0;
    d_addr = 0; d_wdata = 0; ram_ready = 0; ram_data_into_mcu = 0;
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_cs"}, cs, 0);           chk({p, "_we"}, we, 0);
    chk({p, "_oe"}, oe, 0);           chk({p, "_byte_en"}, byte_en, 0);
    chk({p, "_address"}, address, 0); chk({p, "_ram_data_in"}, ram_data_in, 0);
    chk({p, "_if_ready"}, if_ready, 0); chk({p, "_d_ready"}, d_ready, 0);
    chk({p, "_if_rdata"}, if_rdata, 0); chk({p, "_d_rdata"}, d_rdata, 0);
    chk({p, "_if_err"}, if_err, 0);   chk({p, "_d_err"}, d_err, 0);
    chk({p, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_if = 0;
    exp_d  = 0;
  endtask

  // One request on one channel; acts as the RAM, answering on ACCESS cycle waits+1.
  task automatic txn(input bit isd, input bit wr_i, input logic [1:0] sz, input bit sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                     input int waits);
    bit done;
    if (isd) begin
      d_req = 1; d_we = wr_i; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1; if_addr = a;
    end
    ram_ready = 0;
    lat = 0; ncs = 0; o_be = 0; o_ad = 0; o_wb = 0; o_wr = 0; o_oe = 0; o_er = 0; o_rd = 0;
    o_stable = 1; o_one = 1; done = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cs) begin
        ncs++;
        if (ncs == 1) begin
          o_be = byte_en; o_ad = address; o_wb = ram_data_in; o_wr = we; o_oe = oe;
        end else if (byte_en !== o_be || address !== o_ad || ram_data_in !== o_wb ||
                     we !== o_wr || oe !== o_oe) begin
          o_stable = 0;
        end
        ram_ready = (ncs == waits + 1);
        ram_data_into_mcu = (ncs == waits + 1) ? rw : $urandom;
      end else begin
        ram_ready = 0;
      end
      if (isd ? d_ready : if_ready) begin
        done = 1;
        o_er = isd ? d_err : if_err;
        o_rd = isd ? d_rdata : if_rdata;
        if_req = 0;
        d_req  = 0;
      end
    end
    ram_ready = 0;
    if_req = 0;
    d_req  = 0;
    @(negedge clk);
    if (if_ready || d_ready) o_one = 0;
  endtask

  initial begin
    // Directed vectors: {we, size, signed, addr, wdata, ram word, waits, err, byte_en, bus, rdata}
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,         32'h80AA_BBCC, 0, 1'b0, 4'h8, 32'h0,         32'hFFFF_FF80};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_5678, 32'h0,         1, 1'b0, 4'hC, 32'h5678_5678, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,         32'h80AA_BBCC, 2, 1'b0, 4'h2, 32'h0,         32'h0000_00BB};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h002, 32'h0,         32'h80AA_BBCC, 0, 1'b0, 4'hC, 32'h0,         32'hFFFF_80AA};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h000, 32'h0,         32'h1234_F00D, 1, 1'b0, 4'h3, 32'h0,         32'h0000_F00D};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h004, 32'h0,         32'h0000_7FFF, 0, 1'b0, 4'h3, 32'h0,         32'h0000_7FFF};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h008, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h301, 32'hAABB_CCDD, 32'h0,         0, 1'b0, 4'h2, 32'hDDDD_DDDD, 32'h0};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h30C, 32'hCAFE_F00D, 32'h0,         2, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,         32'h1111_1111, 0, 1'b1, 4'h0, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h101, 32'h0,         32'h2222_2222, 0, 1'b1, 4'h0, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,         32'h3333_3333, 0, 1'b1, 4'h0, 32'h0,         32'h0};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 32'h000, 32'h0,         32'h0000_007F, 1, 1'b0, 4'h1, 32'h0,         32'h0000_007F};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h101, 32'h5555_AAAA, 32'h0,         0, 1'b1, 4'h0, 32'h0,         32'h0};

    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    exp_if = 0;
    exp_d  = 0;

    // Both requests held from reset: data, fetch, data, fetch at 3-cycle spacing
    d_we = 0; d_size = 2'd2; d_addr = 32'h10; if_addr = 32'h20;
    ram_ready = 1; ram_data_into_mcu = 32'h5A5A_0001;
    if_req = 1; d_req = 1;
    pat_d = 0; pat_i = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pat_d[c] = d_ready;
      pat_i[c] = if_ready;
    end
    if_req = 0; d_req = 0; ram_ready = 0;
    chk("tie_d_ready_pattern", {20'd0, pat_d}, 32'h0000_0082);
    chk("tie_if_ready_pattern", {20'd0, pat_i}, 32'h0000_0410);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      txn(1'b1, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, tbl[i].rw, tbl[i].waits);
      if (!tbl[i].err && !tbl[i].wr) exp_d = tbl[i].rdata;
      chk($sformatf("tbl%0d_err", i), o_er, tbl[i].err);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].err ? 1 : tbl[i].waits + 2);
      chk($sformatf("tbl%0d_cs_cycles", i), ncs, tbl[i].err ? 0 : tbl[i].waits + 1);
      chk($sformatf("tbl%0d_rdata", i), o_rd, exp_d);
      chk($sformatf("tbl%0d_single_pulse", i), o_one, 1);
      if (!tbl[i].err) begin
        chk($sformatf("tbl%0d_address", i), o_ad, tbl[i].a & 32'hFFFF_FFFC);
        chk($sformatf("tbl%0d_byte_en", i), o_be, tbl[i].be);
        chk($sformatf("tbl%0d_we", i), o_wr, tbl[i].wr);
        chk($sformatf("tbl%0d_oe", i), o_oe, !tbl[i].wr);
        chk($sformatf("tbl%0d_stable", i), o_stable, 1);
        if (tbl[i].wr) chk($sformatf("tbl%0d_ram_data_in", i), o_wb, tbl[i].wbus);
      end
    end

    for (int n = 0; n < 80; n++) begin
      r_isd = $urandom_range(0, 1);
      r_wr  = $urandom_range(0, 1);
      r_sg  = $urandom_range(0, 1);
      r_sz  = $urandom_range(0, 3);
      r_a   = 32'h1000 + $urandom_range(0, 1023);
      r_wd  = $urandom;
      r_rw  = $urandom;
      r_wt  = $urandom_range(0, 3);
      e_err = r_isd && m_illegal(r_sz, r_a);
      txn(r_isd, r_wr, r_sz[1:0], r_sg, r_a, r_wd, r_rw, int'(r_wt));
      chk("rnd_err", o_er, e_err);
      chk("rnd_latency", lat, e_err ? 1 : r_wt + 2);
      if (!e_err) begin
        chk("rnd_address", o_ad, r_a - r_a % 4);
        chk("rnd_byte_en", o_be, m_be(r_isd, r_sz, r_a));
        chk("rnd_we", o_wr, r_isd && r_wr);
        chk("rnd_oe", o_oe, !(r_isd && r_wr));
        if (r_isd && r_wr) chk("rnd_ram_data_in", o_wb, m_wbus(r_sz, r_wd));
        else if (r_isd)    exp_d  = m_load(r_sz, r_sg, r_a, r_rw);
        else               exp_if = r_rw;
      end
      chk("rnd_rdata", o_rd, r_isd ? exp_d : exp_if);
    end

`ifdef MAU_TIMEOUT_EN
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h1111_2222, 100);
    chk("timeout_cs_cycles", ncs, 4);
    chk("timeout_err", o_er, 1);
    chk("timeout_latency", lat, 5);
    chk("timeout_rdata_kept", o_rd, exp_if);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 32'h3333_4444, 3);
    exp_if = 32'h3333_4444;
    chk("late_ready_cs_cycles", ncs, 4);
    chk("late_ready_err", o_er, 0);
    chk("late_ready_rdata", o_rd, exp_if);
`else
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h1111_2222, 10);
    exp_if = 32'h1111_2222;
    chk("long_wait_cs_cycles", ncs, 11);
    chk("long_wait_err", o_er, 0);
    chk("long_wait_rdata", o_rd, exp_if);
`endif

    // Reset during a fetch with 3 wait states
    if_req = 1; if_addr = 32'h40; ram_ready = 0;
    @(negedge clk);
    chk("abort_cs_before_reset", cs, 1);
    @(negedge clk);
    rst = 1; if_req = 0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 0;
    exp_if = 0;
    exp_d  = 0;
    nready = 0;
    ram_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_ready || d_ready) nready++;
    end
    ram_ready = 0;
    chk("abort_no_ready", nready, 0);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 32'h7777_8888, 1);
    exp_if = 32'h7777_8888;
    chk("after_abort_latency", lat, 3);
    chk("after_abort_err", o_er, 0);
    chk("after_abort_rdata", o_rd, exp_if);
    chk("after_abort_address", o_ad, 32'h48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Two-channel memory access sequencer that replaces the core's hard-wired `cs`/`we`/`oe` strobes with a real request/ready protocol toward RAM. It arbitrates between an instruction-fetch channel and a data load/store channel. It handles byte, halfword and word transfers with little-endian lane steering, sign/zero extension and alignment checking, and optionally bounds wait states with a timeout. It sits between the state machine/IR/MRDR/MWDR logic and the external RAM port of `ARMv4`, generalising the current single-path memory controller.

## Interface
Parameters:
- `ADDR_W`, default 32: address width on both channels and on the RAM side.
- `TIMEOUT`, default 64: maximum ACCESS cycles before abort (used only with `MAU_TIMEOUT_EN`); must be ≥1.

Ports. Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: synchronous active-high reset.
- `if_req` in 1: fetch request, held until `if_ready`.
- `if_addr` in ADDR_W: fetch address; bits [1:0] ignored (forced 0).
- `if_ready` out 1: one-cycle completion pulse.
- `if_rdata` out 32: fetched word, registered.
- `if_err` out 1: valid with `if_ready`; timeout.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as error).
- `d_signed` in 1: sign-extend byte/halfword loads.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in 32: store data, right-justified.
- `d_ready` out 1: one-cycle completion pulse.
- `d_rdata` out 32: extended load data, registered.
- `d_err` out 1: valid with `d_ready`; misalign, reserved size or timeout.
- `address` out ADDR_W: RAM address, word-aligned ([1:0] = 0).
- `ram_data_in` out 32: RAM write data, lane-replicated.
- `ram_data_into_mcu` in 32: RAM read data.
- `ram_ready` in 1: RAM completion, sampled in ACCESS only.
- `cs`, `we`, `oe` out 1 each: RAM strobes.
- `byte_en` out 4: lane enables.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - Grant rule: if only one `req` is high, grant it. If both are high, grant the channel not granted last. The last-grant register resets to fetch, so data wins the first tie.
  - Granted request with an illegal data access (`d_size`=11; halfword with addr[0]=1; word with addr[1:0]≠0) → RESP with err=1. No RAM cycle is issued.
  - Granted request that is legal → latch channel, address, size, signed and write data; go to ACCESS.
- **ACCESS**
  - `cs`=1.
  - `oe`=1 for reads, `we`=1 for writes.
  - `address` = latched addr with [1:0]=0.
  - `byte_en`:
    - word = 1111;
    - half = 0011 << (2·a[1]);
    - byte = 0001 << a[1:0];
    - fetch = 1111.
  - `ram_data_in`: store byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - `ram_ready`=1 → go to RESP. For reads, capture the steered and extended data into the granted channel's rdata register.
  - Byte load result = lane a[1:0]; halfword load result = lanes selected by a[1]. Extension is sign or zero per `d_signed`. Fetch always returns the full word.
- **RESP**
  - Assert the granted channel's `ready` for exactly one cycle, with `err` equal to the latched error. Then go to IDLE.
  - All RAM strobes and `byte_en` are 0.
- `rdata` holds until that channel's next successful read. It is unchanged on stores and errors.
- A request is accepted only in IDLE. The requester drops `req` in the cycle after seeing `ready`; a `req` still high at that point is a new request.

## Timing
- Reset value of every output is 0: `cs`, `we`, `oe`, `byte_en`, `address`, `ram_data_in`, both `ready`, both `rdata`, both `err`, `busy`. State resets to IDLE.
- Legal access:
  - `req` seen at edge k → ACCESS cycles k+1 … → `ready` in the cycle after the edge that sampled `ram_ready`=1.
  - Zero wait states: `ready` 2 cycles after `req`.
  - Throughput is one access per 3 cycles.
- Illegal access: `ready`+`err` in the cycle after acceptance, with no `cs` pulse.
- Reset asserted mid-access: abort at the next edge; all outputs return to reset values. No `ready` pulse is ever generated for the aborted request.
- When `ram_ready` is low, strobes stay asserted and stable for the whole ACCESS period.

## Configuration
- `MAU_TIMEOUT_EN` defined:
  - Counter width is clog2(TIMEOUT+1). It clears on entry to ACCESS and increments each ACCESS cycle.
  - If TIMEOUT ACCESS cycles elapse without `ram_ready` → RESP with err=1 and rdata unchanged.
  - If `ram_ready` and expiry occur on the same edge, `ram_ready` wins (success).
- `MAU_TIMEOUT_EN` undefined:
  - No counter; ACCESS waits indefinitely.
  - `if_err` is constant 0.
  - `d_err` reports only misalign or reserved size.

## Test plan
- Byte load: `d_addr`=0x103, `d_size`=00, `d_signed`=1, RAM word 0x80AA_BBCC, `ram_ready` immediate → `byte_en`=1000; `d_rdata`=0xFFFF_FF80 with `d_ready` 2 cycles after `req`; `d_err`=0.
- Halfword store: `d_addr`=0x202, `d_wdata`=0x1234_5678 → `address`=0x200, `we`=1, `byte_en`=1100, `ram_data_in`=0x5678_5678.
- Tie arbitration: both `req` held continuously after reset → grant order data, fetch, data, fetch; each `ready` pulse lasts one cycle, with 3 cycles between grants.
- Misaligned word: `d_addr`=0x102, `d_size`=10 → `d_ready`=1, `d_err`=1 one cycle later; `cs` never asserted; `d_rdata` unchanged.
- Timeout (`MAU_TIMEOUT_EN`, `TIMEOUT`=4): fetch with `ram_ready` held 0 → `cs` high 4 cycles, then `if_ready`=`if_err`=1. Repeat with `ram_ready` rising on the 4th ACCESS cycle → `if_err`=0 and data captured.
- Reset mid-access: `rst` pulsed during ACCESS with 3 wait states → next cycle all outputs 0, state IDLE, no `ready` pulse; a new `if_req` is then served normally.
